// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF     = 10;
    localparam int unsigned STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        RSP_NONE  = 3'd0,
        RSP_IF    = 3'd1,
        RSP_D_RD  = 3'd2,
        RSP_D_WR  = 3'd3,
        RSP_D_ERR = 3'd4
    } rsp_sel_e;

    // Starvation counter width: enough for STARVE_MAX, never below 2 bits.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_store_formatter.sv
// Store lane formatting: byte enables, lane-replicated data and an illegal-access flag.
module store_formatter
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        misalign  = 1'b0;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                misalign  = addr_lo[0];
                be        = addr_lo[0] ? 4'b0000 : (4'b0011 << addr_lo);
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                misalign  = |addr_lo;
                be        = (|addr_lo) ? 4'b0000 : 4'b1111;
                wdata_rep = wdata;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data-priority
// with a starvation counter that forces a fetch grant after STARVE_MAX denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    rsp_sel_e         rsp_sel_q, rsp_sel_d;
    logic             grant_if_c, grant_d_c;
    logic [3:0]       fmt_be;
    logic [31:0]      fmt_wdata;
    logic             fmt_bad;
    logic             unused_if_addr_lo;

    // Instruction fetches are always word accesses.
    assign unused_if_addr_lo = ^if_req_addr[1:0];

    store_formatter u_store_formatter (
        .size      (d_req_size),
        .addr_lo   (d_req_addr[1:0]),
        .wdata     (d_req_wdata),
        .be        (fmt_be),
        .wdata_rep (fmt_wdata),
        .misalign  (fmt_bad)
    );

    // Data wins unless fetch has been denied STARVE_MAX cycles in a row.
    always_comb begin
        grant_if_c = 1'b0;
        grant_d_c  = 1'b0;
        if (!rst) begin
            if (d_req_valid && !(if_req_valid && (starve_cnt_q == CNT_W'(STARVE_MAX)))) begin
                grant_d_c = 1'b1;
            end else if (if_req_valid) begin
                grant_if_c = 1'b1;
            end
        end
    end

    assign if_req_ready = grant_if_c;
    assign d_req_ready  = grant_d_c;

    // Memory strobes and the response kind to deliver next cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        rsp_sel_d = RSP_NONE;
        if (grant_if_c) begin
            mem_en    = 1'b1;
            mem_addr  = if_req_addr[ADDR_W-1:2];
            rsp_sel_d = RSP_IF;
        end else if (grant_d_c) begin
            if (fmt_bad) begin
                rsp_sel_d = RSP_D_ERR;
            end else begin
                mem_en   = 1'b1;
                mem_addr = d_req_addr[ADDR_W-1:2];
                if (d_req_we) begin
                    mem_we    = fmt_be;
                    mem_wdata = fmt_wdata;
                    rsp_sel_d = RSP_D_WR;
                end else begin
                    rsp_sel_d = RSP_D_RD;
                end
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (!rst && if_req_valid && !grant_if_c) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_MAX)) ? starve_cnt_q
                                                                : starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rsp_sel_q    <= RSP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_sel_q    <= rsp_sel_d;
        end
    end

    // Responses are masked by rst so a grant followed by reset is dropped.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = 32'h0000_0000;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = 32'h0000_0000;
        d_rsp_err    = 1'b0;
        if (!rst) begin
            case (rsp_sel_q)
                RSP_IF: begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem_rdata;
                end
                RSP_D_RD: begin
                    d_rsp_valid = 1'b1;
                    d_rsp_data  = mem_rdata;
                end
                RSP_D_WR:  d_rsp_valid = 1'b1;
                RSP_D_ERR: begin
                    d_rsp_valid = 1'b1;
                    d_rsp_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic
// against a transaction-level model with a byte-array reference memory.
module tb_mem_arbiter;

    localparam int unsigned AW   = 10;
    localparam int unsigned SMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [1:0]    d_req_size;
    logic [AW-1:0] d_req_addr;
    logic [31:0]   d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_data;
    logic          d_rsp_err;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_size   (d_req_size),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Memory array driven by the DUT's strobes; loads its image on the first edge.
    logic [7:0] mem_arr [1024];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 8'(i * 37 + 11);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= {mem_arr[{mem_addr, 2'd3}], mem_arr[{mem_addr, 2'd2}],
                          mem_arr[{mem_addr, 2'd1}], mem_arr[{mem_addr, 2'd0}]};
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem_arr[{mem_addr, 2'(b)}] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [1024];
    int          starve_m;
    logic        pv_if, pv_d, perr;
    logic [31:0] pdata;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {ref_mem[{a[AW-1:2], 2'd3}], ref_mem[{a[AW-1:2], 2'd2}],
                ref_mem[{a[AW-1:2], 2'd1}], ref_mem[{a[AW-1:2], 2'd0}]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check grant/strobes/responses against the model, advance it.
    task automatic step(input logic r, input logic iv, input logic [AW-1:0] ia,
                        input logic dv, input logic dwe, input logic [1:0] dsz,
                        input logic [AW-1:0] da, input logic [31:0] dwd,
                        output logic o_gi, output logic o_gd);
        logic gd, gi, legal;
        int nb, off;
        logic [3:0]  ewe;
        logic [31:0] ewd;
        @(negedge clk);
        rst = r; if_req_valid = iv; if_req_addr = ia;
        d_req_valid = dv; d_req_we = dwe; d_req_size = dsz; d_req_addr = da; d_req_wdata = dwd;
        #1;
        gd    = !r && dv && !(iv && starve_m >= int'(SMAX));
        gi    = !r && iv && !gd;
        nb    = 1 << dsz;
        off   = int'(da[1:0]);
        legal = (dsz != 2'b11) && (off % nb == 0);
        ewe = 4'b0000;
        ewd = 32'h0;
        if (gd && legal && dwe) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) ewe[b] = 1'b1;
                ewd[8*b +: 8] = dwd[8*(b % nb) +: 8];
            end
        end
        chk("if_req_ready", 32'(if_req_ready), 32'(gi));
        chk("d_req_ready", 32'(d_req_ready), 32'(gd));
        chk("mem_en", 32'(mem_en), 32'(gi || (gd && legal)));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        if (gi) chk("mem_addr_if", 32'(mem_addr), 32'(ia[AW-1:2]));
        else if (gd && legal) chk("mem_addr_d", 32'(mem_addr), 32'(da[AW-1:2]));
        if (gd && legal && dwe) chk("mem_wdata", mem_wdata, ewd);
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(!r && pv_if));
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(!r && pv_d));
        chk("d_rsp_err", 32'(d_rsp_err), 32'(!r && perr));
        if (r || pv_if) chk("if_rsp_data", if_rsp_data, r ? 32'h0 : pdata);
        if (r || pv_d) chk("d_rsp_data", d_rsp_data, r ? 32'h0 : pdata);
        pv_if = gi;
        pv_d  = gd;
        perr  = gd && !legal;
        pdata = 32'h0;
        if (gi) pdata = word_at(ia);
        else if (gd && legal && !dwe) pdata = word_at(da);
        for (int b = 0; b < 4; b++)
            if (ewe[b]) ref_mem[{da[AW-1:2], 2'(b)}] = ewd[8*b +: 8];
        if (!r && iv && !gi) starve_m = (starve_m + 1 > int'(SMAX)) ? int'(SMAX) : starve_m + 1;
        else starve_m = 0;
        o_gi = gi;
        o_gd = gd;
    endtask

    initial begin
        logic gi, gd;
        logic civ, cdv, cwe, cr;
        logic [1:0] csz;
        logic [AW-1:0] cia, cda;
        logic [31:0] cwd;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
        starve_m = 0; pv_if = 0; pv_d = 0; perr = 0; pdata = 0;
        rst = 1'b1; if_req_valid = 0; if_req_addr = 0; d_req_valid = 0; d_req_we = 0;
        d_req_size = 0; d_req_addr = 0; d_req_wdata = 0;

        // Reset with requests pending: everything must stay quiet.
        step(1, 1, 10'h014, 1, 1, 2'b10, 10'h008, 32'hDEADBEEF, gi, gd);
        step(1, 1, 10'h014, 1, 0, 2'b10, 10'h008, 32'h0, gi, gd);

        // Fetch only.
        step(0, 1, 10'h014, 0, 0, 2'b00, 10'h000, 32'h0, gi, gd);
        chk("fetch_word_addr", 32'(mem_addr), 32'd5);

        // sb 0x021 <- 0xAB (also sees the fetch response).
        step(0, 0, 10'h000, 1, 1, 2'b00, 10'h021, 32'h0000_00AB, gi, gd);
        chk("sb_we", 32'(mem_we), 32'h2);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);

        // sh 0x023: misaligned, accepted without a memory access.
        step(0, 0, 10'h000, 1, 1, 2'b01, 10'h023, 32'h1234_5678, gi, gd);
        chk("sh_mis_ready", 32'(d_req_ready), 32'd1);
        chk("sh_mis_en", 32'(mem_en), 32'd0);
        step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 32'h0, gi, gd);
        chk("sh_mis_err", 32'(d_rsp_err), 32'd1);

        // Both ports busy: data, data, data, fetch, repeat.
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 10'h040, 1, 0, 2'b10, 10'h010, 32'h0, gi, gd);
            chk("starve_pattern", 32'(d_req_ready), 32'((k % 4) != 3));
        end

        // lw 0x008 then fetch: data response first, then fetch response.
        step(0, 0, 10'h000, 1, 0, 2'b10, 10'h008, 32'h0, gi, gd);
        step(0, 1, 10'h0C0, 0, 0, 2'b00, 10'h000, 32'h0, gi, gd);
        chk("lw_data", d_rsp_data, word_at(10'h008));
        step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 32'h0, gi, gd);
        chk("fetch_after_lw", if_rsp_data, word_at(10'h0C0));

        // Build starvation, then reset right after a load grant.
        step(0, 1, 10'h100, 1, 0, 2'b10, 10'h008, 32'h0, gi, gd);
        step(0, 1, 10'h100, 1, 0, 2'b10, 10'h008, 32'h0, gi, gd);
        step(1, 1, 10'h100, 1, 0, 2'b10, 10'h008, 32'h0, gi, gd);
        chk("rst_no_rsp", 32'(d_rsp_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 10'h100, 1, 1, 2'b01, 10'h00A, 32'h0000_BEEF, gi, gd);
            chk("post_rst_pattern", 32'(d_req_ready), 32'(k != 3));
        end

        // Randomized traffic; requests are held until the model says they are granted.
        civ = 0; cdv = 0; cwe = 0; csz = 0; cia = 0; cda = 0; cwd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!civ) begin
                civ = ($urandom % 10) < 6;
                cia = 10'($urandom);
            end
            if (!cdv) begin
                cdv = ($urandom % 10) < 6;
                cwe = 1'($urandom);
                csz = 2'($urandom_range(0, 3));
                cda = 10'($urandom);
                cwd = $urandom;
                if (($urandom % 4) != 0) begin
                    if (csz == 2'b01) cda[0] = 1'b0;
                    if (csz == 2'b10) cda[1:0] = 2'b00;
                end
            end
            cr = ($urandom % 50) == 0;
            step(cr, civ, cia, cdv, cwe, csz, cda, cwd, gi, gd);
            if (gi) civ = 0;
            if (gd) cdv = 0;
        end

        // Drain, then read back every word once to catch stray byte writes.
        for (int w = 0; w < 256; w++)
            step(0, 0, 10'h000, 1, 0, 2'b10, 10'(w * 4), 32'h0, gi, gd);
        step(0, 0, 10'h000, 0, 0, 2'b00, 10'h000, 32'h0, gi, gd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
